// File: rtl/serial_sub_ctrl.sv
// ---------------------------------------------------------------------------
// serial_sub_ctrl
//
// Bit-serial unsigned subtractor. A single full-subtractor cell is stepped
// across the operands LSB first, one bit per clock, with the borrow carried
// between bits in a flop. The result is Diff = A - B - Bin (mod 2^WIDTH) and
// Bout = 1 iff A < B + Bin.
//
// Ports
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, sampled only while idle
//   A      in   WIDTH  minuend, captured on the accepting edge
//   B      in   WIDTH  subtrahend, captured on the accepting edge
//   Bin    in   1      initial borrow-in, captured on the accepting edge
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse when a new result is on Diff/Bout
//   Diff   out  WIDTH  registered result, held until the next completion
//   Bout   out  1      registered final borrow
//
// Timing: accept at edge t0, busy for WIDTH cycles, Diff/Bout updated at edge
// t0+WIDTH, done high for the following cycle, next accept at t0+WIDTH+2.
// ---------------------------------------------------------------------------

// One-bit full subtractor: Diff = A ^ B ^ C, Borr when A - B - C < 0.
module full_sub (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic Diff,
    output logic Borr
);

    always_comb begin
        Diff = A ^ B ^ C;
        Borr = (~A & (B | C)) | (B & C);
    end

endmodule

module serial_sub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);

    // Counter must be able to represent WIDTH-1; clog2(WIDTH+1) also keeps
    // WIDTH = 1 at a legal one-bit width.
    localparam int unsigned CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] partial;

    logic             cell_diff;
    logic             cell_borr;
    logic             last_bit;
    logic [WIDTH:0]   partial_ext;
    logic [WIDTH-1:0] partial_next;

    full_sub u_cell (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .C    (borrow),
        .Diff (cell_diff),
        .Borr (cell_borr)
    );

    always_comb begin
        last_bit     = (cnt == CW'(WIDTH - 1));
        // New bit enters at the MSB while the partial result moves right;
        // widening by one bit keeps the slice legal for WIDTH = 1.
        partial_ext  = {cell_diff, partial};
        partial_next = partial_ext[WIDTH:1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
            partial <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            Diff    <= '0;
            Bout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh    <= A;
                        b_sh    <= B;
                        borrow  <= Bin;
                        cnt     <= '0;
                        partial <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end

                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    borrow  <= cell_borr;
                    cnt     <= cnt + 1'b1;
                    partial <= partial_next;
                    if (last_bit) begin
                        Diff  <= partial_next;
                        Bout  <= cell_borr;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    // start is deliberately ignored here, not queued.
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_sub_ctrl
//
// Bench for serial_sub_ctrl at WIDTH = 8. Expected results are queued when an
// operation is launched and compared when the DUT pulses done.
// ---------------------------------------------------------------------------
module tb_serial_sub_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         bin_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .Bin   (bin_in),
        .busy  (busy),
        .done  (done),
        .Diff  (diff),
        .Bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
    } vec_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_pass   = 0;
    int   n_total  = 0;
    int   done_cnt = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // Independent reference: 9-bit subtraction, the top bit is the borrow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W:0] r;
        exp_t e;
        r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        e.diff = r[W-1:0];
        e.bout = r[W];
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            chk("busy_done_exclusive", {31'b0, busy}, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                cur = exp_q.pop_front();
                chk("diff", {24'b0, diff}, {24'b0, cur.diff});
                chk("bout", {31'b0, bout}, {31'b0, cur.bout});
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy && !done) break;
        end
        chk("idle_reached", {30'b0, busy, done}, 0);
    endtask

    // Launch one operation and check the busy/done timing around it.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input logic [W-1:0] xd, input logic xb);
        int busy_n;
        exp_t e;
        wait_idle();
        @(posedge clk); #1;
        a_in = a; b_in = b; bin_in = bin; start = 1'b1;
        e.diff = xd; e.bout = xb;
        exp_q.push_back(e);
        @(posedge clk); #1;          // accepting edge has passed
        start = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) break;
            if (busy) busy_n++;
        end
        chk("done_arrived", {31'b0, done}, 1);
        chk("busy_cycles", busy_n, W);
        @(negedge clk);
        chk("done_one_cycle", {31'b0, done}, 0);
        chk("diff_hold", {24'b0, diff}, {24'b0, xd});
        chk("bout_hold", {31'b0, bout}, {31'b0, xb});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        exp_t e;
        int   d0;
        int   t_prev;
        logic [W-1:0] ra, rb;
        logic rbin;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[2] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

        // Reset with random inputs applied
        rst_n = 1'b1; start = 1'b0;
        a_in = W'($urandom); b_in = W'($urandom); bin_in = 1'($urandom);
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_diff", {24'b0, diff}, 0);
        chk("rst_bout", {31'b0, bout}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_outputs", {22'b0, busy, done, diff, bout}, 0);
        end

        // Table vectors: basic subtract and borrow boundaries
        for (int i = 0; i < 4; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout);

        // Random operands against the reference model
        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
            e = model(ra, rb, rbin);
            run_op(ra, rb, rbin, e.diff, e.bout);
        end

        // Operand isolation and ignored start during RUN/DONE
        wait_idle();
        d0 = done_cnt;
        @(posedge clk); #1;
        a_in = 8'h10; b_in = 8'h01; bin_in = 1'b0; start = 1'b1;
        e.diff = 8'h0F; e.bout = 1'b0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        for (int i = 0; i < W; i++) begin
            a_in = W'($urandom); b_in = W'($urandom); bin_in = 1'($urandom);
            start = 1'($urandom);
            @(posedge clk); #1;
        end
        chk("in_done_state", {31'b0, done}, 1);
        start = 1'b1;                 // seen only by the DONE state
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(negedge clk);
        chk("isolation_done_count", done_cnt - d0, 1);
        chk("isolation_no_extra_op", {31'b0, busy}, 0);

        // Back-to-back with start held high
        wait_idle();
        d0 = done_cnt;
        @(posedge clk); #1;
        a_in = 8'h03; b_in = 8'h05; bin_in = 1'b0; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e.diff = 8'hFE; e.bout = 1'b1;
            exp_q.push_back(e);
        end
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (done) break;
            end
            chk("b2b_done", {31'b0, done}, 1);
            if (k == 2) start = 1'b0;
            if (k > 0) chk("b2b_interval", cyc - t_prev, W + 2);
            t_prev = cyc;
            @(negedge clk);
        end
        chk("b2b_count", done_cnt - d0, 3);

        // Reset during the 4th RUN cycle
        wait_idle();
        @(posedge clk); #1;
        a_in = 8'hC3; b_in = 8'h11; bin_in = 1'b0; start = 1'b1;
        e = model(8'hC3, 8'h11, 1'b0);
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("pre_abort_busy", {31'b0, busy}, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_diff", {24'b0, diff}, 0);
        chk("abort_bout", {31'b0, bout}, 0);
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        run_op(8'h09, 8'h04, 1'b1, 8'h04, 1'b0);

        wait_idle();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
